keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 active-low key matrix, synchronises and debounces it, and encodes a single pressed key as a 4-bit note code.
- Sits directly upstream of game_module.
- key_code drives game_module.keypad_reg; key_press drives game_module.keypad_enable.
- Code 0 is reserved as "no note / silence", matching the game's piezo/LED encoding.

Parameters:
- SCAN_DIV, 50000: clock cycles each column is driven. Must be >= 4 to cover synchroniser plus settling.
- DEBOUNCE_CNT, 4: consecutive identical full-matrix frames required before the debounced map updates. Legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- row_in  in  4  matrix rows, active-low, externally pulled up, asynchronous to clk
- col_out  out  4  column drive, one-hot active-low
- key_code  out  4  code of the last accepted key (1..15)
- key_press  out  1  one-cycle pulse when a new key is accepted (to game keypad_enable)
- key_release  out  1  one-cycle pulse when an accepted key is released
- key_held  out  1  high while an accepted key remains pressed
- multi_key  out  1  high while more than one key is pressed or a key change occurred during a hold

Behaviour:
- One clock domain; reset is synchronous and active-low.
- Reset values: col_out=4'b1110, key_code=0, key_press=0, key_release=0, key_held=0, multi_key=0. Column index=0, divider=0, frame map=0, previous map=0, stable count=0, debounced map=0, state=RELEASED.
- Reset asserted mid-operation returns every register to these values on the next clk edge; no pulse is emitted.
- Synchroniser: row_in passes through 2 flops; the inverted result gives pressed=1.
- Scan timing:
  - The divider counts 0..SCAN_DIV-1 per column.
  - On divider==SCAN_DIV-1, the synchronised rows are stored into frame map bits [col*4 +: 4]; the column then advances 0->1->2->3->0 and col_out rotates its zero.
  - Frame length = 4*SCAN_DIV cycles.
- Key index = col*4+row. Code = index+1 for index 0..14. Index 15 is masked out of the map and can never produce a press.
- Frame-end debounce, on the cycle that column 3 is sampled:
  - Frame map equal to previous map: stable count increments, saturating at DEBOUNCE_CNT.
  - Otherwise: stable count=1.
  - Previous map takes the frame map.
  - When the stable count equals DEBOUNCE_CNT, the debounced map takes the frame map, and a one-cycle "map valid" strobe is raised in the following cycle.
- Control FSM, evaluated on the map-valid strobe only:
  - RELEASED:
    - Map empty: stay.
    - Exactly one bit set: key_code=code, key_press=1 for one cycle, key_held=1, go to HELD.
    - Two or more bits set: multi_key=1, go to BLOCKED, no press.
  - HELD:
    - Map empty: key_held=0, key_release=1 for one cycle, go to RELEASED.
    - Same single key: stay.
    - Any other non-empty map: key_held=0, multi_key=1, go to BLOCKED, no release pulse.
  - BLOCKED:
    - Map empty: multi_key=0, go to RELEASED.
    - Otherwise: stay.
- key_code holds its value after release and after BLOCKED. It changes only on an accepted press.
- key_press and key_release are never high in the same cycle. At most one press occurs per physical press.
- Latency: for a key pressed before a frame start and held clean, key_press fires 1 cycle after the frame end of the DEBOUNCE_CNT-th identical frame, i.e. (DEBOUNCE_CNT+1)*4*SCAN_DIV + 3 cycles worst case including the synchroniser.

Decomposition:
- keypad_pkg:
  - ROWS=4, COLS=4, KEY_NONE=4'd0, KEY_MASKED_IDX=15.
  - state enum {RELEASED, HELD, BLOCKED}.
  - function index_to_code and function popcount16 (or an is_single predicate).
- One sub-module: keypad_frame_debounce. It takes the 16-bit frame map plus a frame-end strobe and outputs the debounced map plus the map-valid strobe.
- Column drive, divider, synchroniser and FSM live in keypad_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, frame=16 cycles):
- Reset: hold reset low 3 cycles. Then col_out=1110 and all outputs 0; col_out rotates 1101 at cycle 4 and 1011 at cycle 8 after release.
- Clean press: pull row2 low whenever col1 is driven (index 6). Require exactly one key_press with key_code=7 and key_held=1 within 4 frames+3 cycles. On release, require one key_release, key_held=0, key_code still 7.
- Bounce: toggle row2/col1 contact every 5 cycles for 40 cycles, then hold stable. Require no key_press during bouncing and exactly one key_press (code 7) afterwards.
- Two keys: press index 0 and index 5 together. Require multi_key=1 and no key_press. Release both: multi_key=0. A subsequent single index-3 press gives key_code=4.
- Masked key: press index 15 only for 10 frames. Require no key_press, multi_key=0, key_code unchanged.
- Reset mid-hold: with index 6 HELD, assert reset for 1 cycle. Outputs return to reset values next edge with no release pulse. With the key still down, a new key_press with code 7 follows after debounce.

Source files
------------

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
//   Shared constants, the control state type and small helpers for the 4x4
//   keypad scanner slice.
//
//   Contents:
//     ROWS, COLS, MAP_W    matrix geometry and width of the key bitmap
//     KEY_NONE             code 0, reserved as "no note / silence"
//     KEY_MASKED_IDX       key index that is never allowed to produce a press
//     key_state_t          RELEASED / HELD / BLOCKED control states
//     index_to_code        key index (col*4+row) to note code
//     popcount16           number of keys set in a 16-bit map
//     lowest_index         index of the lowest set bit of a 16-bit map
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int MAP_W = ROWS * COLS;

  localparam logic [3:0] KEY_NONE       = 4'd0;
  localparam int         KEY_MASKED_IDX = 15;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    HELD     = 2'd1,
    BLOCKED  = 2'd2
  } key_state_t;

  // Note codes start at 1 so that 0 stays free for "silence" downstream.
  function automatic logic [3:0] index_to_code(input logic [3:0] idx);
    return idx + 4'd1;
  endfunction

  // Counts set bits; used to tell an empty, single-key or multi-key map apart.
  function automatic logic [4:0] popcount16(input logic [15:0] map);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, map[i]};
    end
    return cnt;
  endfunction

  // Only meaningful when exactly one bit is set, which is the only case in
  // which the result is consumed.
  function automatic logic [3:0] lowest_index(input logic [15:0] map);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (map[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// -----------------------------------------------------------------------------
// keypad_frame_debounce
//   Whole-frame debouncer. A frame is one complete scan of the 16-key matrix.
//   The debounced map only follows the scanned map once DEBOUNCE_CNT
//   consecutive identical frames have been seen.
//
//   Ports:
//     i_clk        system clock
//     i_reset      synchronous, active-low reset
//     i_frameMap   complete frame map, valid on the frame-end cycle
//     i_frameEnd   one-cycle strobe marking the last column sample of a frame
//     o_debMap     debounced key map
//     o_mapValid   one-cycle strobe, high the cycle after o_debMap is updated
// -----------------------------------------------------------------------------
module keypad_frame_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [MAP_W-1:0] i_frameMap,
  input  logic             i_frameEnd,
  output logic [MAP_W-1:0] o_debMap,
  output logic             o_mapValid
);

  // DEBOUNCE_CNT is limited to 1..15, so four bits hold the stable count.
  localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_CNT);

  logic [MAP_W-1:0] r_prevMap;
  logic [3:0]       r_stableCnt;
  logic [MAP_W-1:0] r_debMap;
  logic             r_mapValid;

  logic             w_sameFrame;
  logic [3:0]       w_nextCnt;

  assign w_sameFrame = (i_frameMap == r_prevMap);

  // Stable count the frame-end update will produce. A repeat of the previous
  // frame extends the run (saturating at the limit so a long hold keeps
  // re-validating the map); any change restarts the run at one, because the
  // new frame is itself the first of a potential run.
  always_comb begin
    w_nextCnt = 4'd1;
    if (w_sameFrame) begin
      w_nextCnt = (r_stableCnt == DEB_LIMIT) ? r_stableCnt : r_stableCnt + 4'd1;
    end
  end

  // Frame-end bookkeeping. The map is committed in the same cycle the run
  // reaches the limit; the valid strobe is registered alongside it, so it is
  // seen by the consumer one cycle after the frame end.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_prevMap   <= '0;
      r_stableCnt <= 4'd0;
      r_debMap    <= '0;
      r_mapValid  <= 1'b0;
    end else begin
      r_mapValid <= 1'b0;
      if (i_frameEnd) begin
        r_prevMap   <= i_frameMap;
        r_stableCnt <= w_nextCnt;
        if (w_nextCnt == DEB_LIMIT) begin
          r_debMap   <= i_frameMap;
          r_mapValid <= 1'b1;
        end
      end
    end
  end

  assign o_debMap   = r_debMap;
  assign o_mapValid = r_mapValid;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 active-low key matrix, synchronises and debounces it, and
//   turns a single accepted key into a 4-bit note code for game_module.
//
//   Ports:
//     i_clk          system clock
//     i_reset        synchronous, active-low reset
//     i_row_in       matrix rows, active-low, asynchronous to i_clk
//     o_col_out      column drive, one-hot active-low
//     o_key_code     code of the last accepted key (1..15), 0 after reset
//     o_key_press    one-cycle pulse on a newly accepted key
//     o_key_release  one-cycle pulse when the accepted key is released
//     o_key_held     high while the accepted key remains pressed
//     o_multi_key    high while several keys are down or the key changed
//                    during a hold, until the matrix is empty again
//
//   SCAN_DIV is the number of cycles each column is driven (>= 4, so that the
//   two-flop synchroniser has settled before the column is sampled).
//   DEBOUNCE_CNT is the number of identical frames required (1..15).
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [ROWS-1:0] i_row_in,
  output logic [COLS-1:0] o_col_out,
  output logic [3:0]      o_key_code,
  output logic            o_key_press,
  output logic            o_key_release,
  output logic            o_key_held,
  output logic            o_multi_key
);

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Synchroniser, scan timing and frame capture
  logic [ROWS-1:0]  r_rowSync1;
  logic [ROWS-1:0]  r_rowSync2;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col;
  logic [COLS-1:0]  r_colOut;
  logic [MAP_W-1:0] r_frameMap;

  logic [ROWS-1:0]  w_rowPressed;
  logic             w_divEnd;
  logic             w_frameEnd;
  logic [MAP_W-1:0] w_frameNext;

  // Debounced view of the matrix
  logic [MAP_W-1:0] w_debMap;
  logic             w_mapValid;
  logic [4:0]       w_popCount;
  logic [3:0]       w_keyIdx;

  // Control FSM and its registered outputs
  key_state_t       r_state;
  logic [MAP_W-1:0] r_keyMap;
  logic [3:0]       r_keyCode;
  logic             r_keyPress;
  logic             r_keyRelease;
  logic             r_keyHeld;
  logic             r_multiKey;

  // Two-flop synchroniser for the asynchronous rows. The idle value is all
  // ones (pulled up, nothing pressed) so reset never looks like a keypress.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_rowSync1 <= '1;
      r_rowSync2 <= '1;
    end else begin
      r_rowSync1 <= i_row_in;
      r_rowSync2 <= r_rowSync1;
    end
  end

  assign w_rowPressed = ~r_rowSync2;
  assign w_divEnd     = (r_div == DIV_LAST);
  assign w_frameEnd   = w_divEnd && (r_col == 2'd3);

  // The frame map as it will look after this cycle's sample. Feeding this to
  // the debouncer lets the frame-end comparison include column 3 on the very
  // cycle it is sampled. The masked key is forced to zero here so it can
  // never reach the debouncer or the FSM.
  always_comb begin
    w_frameNext = r_frameMap;
    if (w_divEnd) begin
      w_frameNext[{r_col, 2'b00} +: ROWS] = w_rowPressed;
    end
    w_frameNext[KEY_MASKED_IDX] = 1'b0;
  end

  // Column sequencing: each column is driven for SCAN_DIV cycles, its rows are
  // captured on the last of those cycles, then the active-low drive rotates to
  // the next column.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_div      <= '0;
      r_col      <= 2'd0;
      r_colOut   <= 4'b1110;
      r_frameMap <= '0;
    end else begin
      if (w_divEnd) begin
        r_div      <= '0;
        r_col      <= r_col + 2'd1;
        r_colOut   <= {r_colOut[COLS-2:0], r_colOut[COLS-1]};
        r_frameMap <= w_frameNext;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  keypad_frame_debounce #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_debounce (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_frameMap (w_frameNext),
    .i_frameEnd (w_frameEnd),
    .o_debMap   (w_debMap),
    .o_mapValid (w_mapValid)
  );

  assign w_popCount = popcount16(w_debMap);
  assign w_keyIdx   = lowest_index(w_debMap);

  // Control FSM. It only moves on a fresh debounced map, so bounce that never
  // produced DEBOUNCE_CNT identical frames is invisible here. Press and
  // release pulses default low every cycle; only one of them can be set per
  // transition, so they never overlap. key_code is written only on an
  // accepted press and otherwise keeps the last note.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= RELEASED;
      r_keyMap     <= '0;
      r_keyCode    <= KEY_NONE;
      r_keyPress   <= 1'b0;
      r_keyRelease <= 1'b0;
      r_keyHeld    <= 1'b0;
      r_multiKey   <= 1'b0;
    end else begin
      r_keyPress   <= 1'b0;
      r_keyRelease <= 1'b0;
      if (w_mapValid) begin
        case (r_state)
          RELEASED: begin
            if (w_popCount == 5'd1) begin
              r_keyMap   <= w_debMap;
              r_keyCode  <= index_to_code(w_keyIdx);
              r_keyPress <= 1'b1;
              r_keyHeld  <= 1'b1;
              r_state    <= HELD;
            end else if (w_popCount != 5'd0) begin
              r_multiKey <= 1'b1;
              r_state    <= BLOCKED;
            end
          end
          HELD: begin
            if (w_popCount == 5'd0) begin
              r_keyHeld    <= 1'b0;
              r_keyRelease <= 1'b1;
              r_state      <= RELEASED;
            end else if (w_debMap != r_keyMap) begin
              // A second key or a slide to another key: drop the hold
              // silently and wait for the matrix to clear.
              r_keyHeld  <= 1'b0;
              r_multiKey <= 1'b1;
              r_state    <= BLOCKED;
            end
          end
          BLOCKED: begin
            if (w_popCount == 5'd0) begin
              r_multiKey <= 1'b0;
              r_state    <= RELEASED;
            end
          end
          default: begin
            r_state <= RELEASED;
          end
        endcase
      end
    end
  end

  assign o_col_out     = r_colOut;
  assign o_key_code    = r_keyCode;
  assign o_key_press   = r_keyPress;
  assign o_key_release = r_keyRelease;
  assign o_key_held    = r_keyHeld;
  assign o_multi_key   = r_multiKey;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//   Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3
//   (16-cycle frames). A behavioural key matrix pulls a row low whenever the
//   column of a held key is driven.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int FRAME        = 4 * SCAN_DIV;
  localparam int PRESS_BUDGET = (DEBOUNCE_CNT + 1) * FRAME + 3;
  localparam int WAIT_BUDGET  = 8 * FRAME;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  rowIn;
  logic [3:0]  colOut;
  logic [3:0]  keyCode;
  logic        keyPress;
  logic        keyRelease;
  logic        keyHeld;
  logic        multiKey;

  logic [15:0] keysDown = 16'h0000;

  int checks = 0;
  int passes = 0;
  int pressCount = 0;
  int releaseCount = 0;
  bit bothHigh = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_row_in      (rowIn),
    .o_col_out     (colOut),
    .o_key_code    (keyCode),
    .o_key_press   (keyPress),
    .o_key_release (keyRelease),
    .o_key_held    (keyHeld),
    .o_multi_key   (multiKey)
  );

  // Key matrix model: a held key at index col*4+row shorts its row to the
  // column line, so the row reads low only while that column is driven low.
  always_comb begin
    rowIn = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!colOut[c] && keysDown[c*4+r]) begin
          rowIn[r] = 1'b0;
        end
      end
    end
  end

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (keyPress)   pressCount++;
    if (keyRelease) releaseCount++;
    if (keyPress && keyRelease) bothHigh = 1'b1;
  end

  task automatic waitPress(input int budget, output bit seen,
                           output logic [3:0] code, output logic held);
    seen = 1'b0;
    code = 4'hX;
    held = 1'bX;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (keyPress) begin
        seen = 1'b1;
        code = keyCode;
        held = keyHeld;
        break;
      end
    end
  endtask

  task automatic waitRelease(input int budget, output bit seen,
                             output logic [3:0] code, output logic held);
    seen = 1'b0;
    code = 4'hX;
    held = 1'bX;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (keyRelease) begin
        seen = 1'b1;
        code = keyCode;
        held = keyHeld;
        break;
      end
    end
  endtask

  task automatic waitMulti(input logic level, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (multiKey === level) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (colOut !== 4'b1110) $display("[TB] FAIL reset_col_out got %b want 1110", colOut); else passes++;
    checks++; if (keyCode !== 4'd0) $display("[TB] FAIL reset_key_code got %0d want 0", keyCode); else passes++;
    checks++; if ({keyPress, keyRelease, keyHeld, multiKey} !== 4'b0000)
      $display("[TB] FAIL reset_flags got %b want 0000", {keyPress, keyRelease, keyHeld, multiKey}); else passes++;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (colOut !== 4'b1110) $display("[TB] FAIL col_hold_3 got %b want 1110", colOut); else passes++;
    @(negedge clk);
    checks++; if (colOut !== 4'b1101) $display("[TB] FAIL col_rot_4 got %b want 1101", colOut); else passes++;
    repeat (4) @(negedge clk);
    checks++; if (colOut !== 4'b1011) $display("[TB] FAIL col_rot_8 got %b want 1011", colOut); else passes++;
    // Let the empty map settle through the debouncer before pressing keys.
    repeat (4 * FRAME) @(negedge clk);
  endtask

  task automatic test_clean_press();
    bit seen;
    logic [3:0] code;
    logic held;
    int p0, r0;
    p0 = pressCount;
    r0 = releaseCount;
    keysDown = 16'h0040;
    waitPress(PRESS_BUDGET, seen, code, held);
    checks++; if (!seen) $display("[TB] FAIL clean_press_seen got none want pulse within %0d", PRESS_BUDGET); else passes++;
    checks++; if (code !== 4'd7) $display("[TB] FAIL clean_press_code got %0d want 7", code); else passes++;
    checks++; if (held !== 1'b1) $display("[TB] FAIL clean_press_held got %b want 1", held); else passes++;
    repeat (3 * FRAME) @(negedge clk);
    checks++; if (pressCount - p0 !== 1) $display("[TB] FAIL clean_press_count got %0d want 1", pressCount - p0); else passes++;
    keysDown = 16'h0000;
    waitRelease(WAIT_BUDGET, seen, code, held);
    checks++; if (!seen) $display("[TB] FAIL clean_release_seen got none want pulse"); else passes++;
    checks++; if (held !== 1'b0) $display("[TB] FAIL clean_release_held got %b want 0", held); else passes++;
    checks++; if (code !== 4'd7) $display("[TB] FAIL clean_release_code got %0d want 7", code); else passes++;
    repeat (2 * FRAME) @(negedge clk);
    checks++; if (releaseCount - r0 !== 1) $display("[TB] FAIL clean_release_count got %0d want 1", releaseCount - r0); else passes++;
  endtask

  task automatic test_bounce();
    bit seen;
    logic [3:0] code;
    logic held;
    int p0;
    p0 = pressCount;
    for (int i = 0; i < 8; i++) begin
      keysDown[6] = ~keysDown[6];
      repeat (5) @(negedge clk);
    end
    checks++; if (pressCount - p0 !== 0) $display("[TB] FAIL bounce_no_press got %0d want 0", pressCount - p0); else passes++;
    keysDown = 16'h0040;
    waitPress(WAIT_BUDGET, seen, code, held);
    checks++; if (!seen) $display("[TB] FAIL bounce_press_seen got none want pulse"); else passes++;
    checks++; if (code !== 4'd7) $display("[TB] FAIL bounce_press_code got %0d want 7", code); else passes++;
    repeat (3 * FRAME) @(negedge clk);
    checks++; if (pressCount - p0 !== 1) $display("[TB] FAIL bounce_press_count got %0d want 1", pressCount - p0); else passes++;
    keysDown = 16'h0000;
    waitRelease(WAIT_BUDGET, seen, code, held);
    checks++; if (!seen) $display("[TB] FAIL bounce_release_seen got none want pulse"); else passes++;
  endtask

  task automatic test_two_keys();
    bit seen;
    logic [3:0] code;
    logic held;
    int p0;
    p0 = pressCount;
    keysDown = 16'h0021;
    waitMulti(1'b1, WAIT_BUDGET, seen);
    checks++; if (!seen) $display("[TB] FAIL two_keys_multi got %b want 1", multiKey); else passes++;
    repeat (2 * FRAME) @(negedge clk);
    checks++; if (pressCount - p0 !== 0) $display("[TB] FAIL two_keys_no_press got %0d want 0", pressCount - p0); else passes++;
    keysDown = 16'h0000;
    waitMulti(1'b0, WAIT_BUDGET, seen);
    checks++; if (!seen) $display("[TB] FAIL two_keys_clear got %b want 0", multiKey); else passes++;
    checks++; if (pressCount - p0 !== 0) $display("[TB] FAIL two_keys_release_no_press got %0d want 0", pressCount - p0); else passes++;
    keysDown = 16'h0008;
    waitPress(WAIT_BUDGET, seen, code, held);
    checks++; if (!seen) $display("[TB] FAIL idx3_press_seen got none want pulse"); else passes++;
    checks++; if (code !== 4'd4) $display("[TB] FAIL idx3_press_code got %0d want 4", code); else passes++;
    keysDown = 16'h0000;
    waitRelease(WAIT_BUDGET, seen, code, held);
    checks++; if (!seen) $display("[TB] FAIL idx3_release_seen got none want pulse"); else passes++;
  endtask

  task automatic test_masked_key();
    int p0;
    bit sawMulti;
    p0 = pressCount;
    sawMulti = 1'b0;
    keysDown = 16'h8000;
    for (int i = 0; i < 10 * FRAME; i++) begin
      @(negedge clk);
      if (multiKey) sawMulti = 1'b1;
    end
    checks++; if (pressCount - p0 !== 0) $display("[TB] FAIL masked_no_press got %0d want 0", pressCount - p0); else passes++;
    checks++; if (sawMulti !== 1'b0) $display("[TB] FAIL masked_multi got %b want 0", sawMulti); else passes++;
    checks++; if (keyCode !== 4'd4) $display("[TB] FAIL masked_code got %0d want 4", keyCode); else passes++;
    keysDown = 16'h0000;
    repeat (4 * FRAME) @(negedge clk);
  endtask

  task automatic test_reset_mid_hold();
    bit seen;
    logic [3:0] code;
    logic held;
    int r0;
    keysDown = 16'h0040;
    waitPress(WAIT_BUDGET, seen, code, held);
    checks++; if (!seen || code !== 4'd7) $display("[TB] FAIL midreset_first_press got seen=%b code=%0d want 1/7", seen, code); else passes++;
    repeat (FRAME) @(negedge clk);
    r0 = releaseCount;
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({keyHeld, keyPress, keyRelease, multiKey} !== 4'b0000)
      $display("[TB] FAIL midreset_flags got %b want 0000", {keyHeld, keyPress, keyRelease, multiKey}); else passes++;
    checks++; if (keyCode !== 4'd0) $display("[TB] FAIL midreset_code got %0d want 0", keyCode); else passes++;
    checks++; if (colOut !== 4'b1110) $display("[TB] FAIL midreset_col got %b want 1110", colOut); else passes++;
    reset = 1'b1;
    waitPress(WAIT_BUDGET, seen, code, held);
    checks++; if (!seen) $display("[TB] FAIL midreset_repress_seen got none want pulse"); else passes++;
    checks++; if (code !== 4'd7) $display("[TB] FAIL midreset_repress_code got %0d want 7", code); else passes++;
    checks++; if (releaseCount - r0 !== 0) $display("[TB] FAIL midreset_no_release got %0d want 0", releaseCount - r0); else passes++;
    keysDown = 16'h0000;
    waitRelease(WAIT_BUDGET, seen, code, held);
    checks++; if (!seen) $display("[TB] FAIL midreset_release_seen got none want pulse"); else passes++;
  endtask

  initial begin
    $display("[TB] keypad_scanner directed bench start");
    test_reset();
    test_clean_press();
    test_bounce();
    test_two_keys();
    test_masked_key();
    test_reset_mid_hold();
    checks++; if (bothHigh !== 1'b0) $display("[TB] FAIL press_release_overlap got %b want 0", bothHigh); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
